// File: rtl/dragster_spi_responder.sv
// dragster_spi_responder: SPI mode-0 target standing in for the Dragster linear
// sensor configuration port. It deserializes 16-bit MSB-first frames
// {data[7:0], rd, addr[6:0]} into an 8-bit register file and exposes the registers
// and write strobes in parallel.
// Optional feature macro: DRAGSTER_SPI_READBACK_EN adds the response register so
// that read frames return register contents on miso. Without it, miso and
// miso_oe are tied low and read frames are dropped.
module dragster_spi_responder #(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int UPDATE_ADDR = 1,
  parameter int UPDATE_BIT  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  reg_wr_strobe,
  output logic [6:0]            reg_wr_addr,
  output logic [7:0]            reg_wr_data,
  output logic                  update_pulse,
  output logic                  frame_error,
  output logic [8*NUM_REGS-1:0] cfg_regs
);

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_COMMIT    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic                   ss_dly_q, ss_dly_d;
  logic                   sclk_s, mosi_s, ss_s;
  logic                   sclk_rise_s, ss_fall_s, ss_rise_s;

  logic [15:0]            rx_q, rx_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [8*NUM_REGS-1:0]  cfg_q, cfg_d;
  logic                   strobe_q, strobe_d;
  logic                   upd_q, upd_d;
  logic                   ferr_q, ferr_d;
  logic [6:0]             wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;

  logic                   frame_ok_s, is_read_s, addr_ok_s;
  logic [6:0]             addr_s;
  logic [7:0]             data_s;

  // Synchroniser shift chains and one-cycle delayed copies for edge detection
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
    sclk_dly_d  = sclk_s;
    ss_dly_d    = ss_s;
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_dly_q;
  assign ss_fall_s   = ~ss_s & ss_dly_q;
  assign ss_rise_s   = ss_s & ~ss_dly_q;

  // Frame decode of the received word
  assign frame_ok_s = (cnt_q == 5'd16);
  assign is_read_s  = rx_q[7];
  assign addr_s     = rx_q[6:0];
  assign data_s     = rx_q[15:8];
  assign addr_ok_s  = ({25'd0, addr_s} < NUM_REGS);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; WAIT_IDLE keeps a frame already in flight at reset release from starting
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_IDLE: if (ss_s)      state_d = ST_IDLE;   else state_d = ST_WAIT_IDLE;
      ST_IDLE:      if (ss_fall_s) state_d = ST_SHIFT;  else state_d = ST_IDLE;
      ST_SHIFT:     if (ss_rise_s) state_d = ST_COMMIT; else state_d = ST_SHIFT;
      ST_COMMIT:    state_d = ST_IDLE;
      default:      state_d = ST_WAIT_IDLE;
    endcase
  end

  // Datapath: bit capture, frame commit and one-cycle output pulses
  always_comb begin
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    cfg_d     = cfg_q;
    strobe_d  = 1'b0;
    upd_d     = 1'b0;
    ferr_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall_s) begin
          cnt_d = 5'd0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise_s && !ss_s) begin
          rx_d  = {rx_q[14:0], mosi_s};
          cnt_d = (cnt_q == 5'd17) ? cnt_q : (cnt_q + 5'd1);
        end else begin
          rx_d  = rx_q;
        end
      end
      ST_COMMIT: begin
        if (!frame_ok_s) begin
          ferr_d = 1'b1;
        end else if (!is_read_s && addr_ok_s) begin
          strobe_d  = 1'b1;
          wr_addr_d = addr_s;
          wr_data_d = data_s;
          upd_d     = (addr_s == 7'(UPDATE_ADDR)) && rx_q[8+UPDATE_BIT];
          for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_s == 7'(i)) begin
              cfg_d[8*i +: 8] = data_s;
            end else begin
              cfg_d[8*i +: 8] = cfg_q[8*i +: 8];
            end
          end
        end else begin
          // Out-of-range writes and read frames leave the register file alone
          cfg_d = cfg_q;
        end
      end
      default: begin
        rx_d = rx_q;
      end
    endcase
  end

  // Synchroniser, shift register, counter, register file and output flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
      sclk_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b0;
      rx_q        <= 16'h0000;
      cnt_q       <= 5'd0;
      cfg_q       <= '0;
      strobe_q    <= 1'b0;
      upd_q       <= 1'b0;
      ferr_q      <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 8'h00;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      ss_dly_q    <= ss_dly_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
      strobe_q    <= strobe_d;
      upd_q       <= upd_d;
      ferr_q      <= ferr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign reg_wr_strobe = strobe_q;
  assign reg_wr_addr   = wr_addr_q;
  assign reg_wr_data   = wr_data_q;
  assign update_pulse  = upd_q;
  assign frame_error   = ferr_q;
  assign cfg_regs      = cfg_q;

`ifdef DRAGSTER_SPI_READBACK_EN
  logic [15:0] resp_q, resp_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0]  rd_data_s;
  logic        sclk_fall_s;

  assign sclk_fall_s = ~sclk_s & sclk_dly_q;

  // Read mux selecting the addressed register
  always_comb begin
    rd_data_s = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_s == 7'(i)) begin
        rd_data_s = cfg_q[8*i +: 8];
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  // Response word for the next frame and the miso shifter; outside SHIFT the
  // shifter tracks the response so bit 15 is ready the moment ss_n falls
  always_comb begin
    resp_d = resp_q;
    tx_d   = tx_q;
    if (state_q == ST_COMMIT && frame_ok_s) begin
      if (is_read_s) begin
        resp_d = addr_ok_s ? {rd_data_s, rx_q[7:0]} : {8'h00, rx_q[7:0]};
      end else begin
        resp_d = rx_q;
      end
    end else begin
      resp_d = resp_q;
    end
    if (state_q == ST_SHIFT) begin
      if (sclk_fall_s && !ss_s) begin
        tx_d = {tx_q[14:0], 1'b0};
      end else begin
        tx_d = tx_q;
      end
    end else begin
      tx_d = resp_q;
    end
  end

  // Response and miso shift registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_q <= 16'h0000;
      tx_q   <= 16'h0000;
    end else begin
      resp_q <= resp_d;
      tx_q   <= tx_d;
    end
  end

  // Driver enabled straight from the pin, but never before a clean idle has been seen
  assign miso_oe = ~ss_n & (state_q != ST_WAIT_IDLE);
  assign miso    = miso_oe & tx_q[15];
`else
  assign miso_oe = 1'b0;
  assign miso    = 1'b0;
`endif

endmodule

// File: tb/tb_dragster_spi_responder.sv
// Directed self-checking bench for dragster_spi_responder (SPI master model, sclk = clk/10).
module tb_dragster_spi_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         sclk;
  logic         mosi;
  logic         ss_n;
  logic         miso;
  logic         miso_oe;
  logic         reg_wr_strobe;
  logic [6:0]   reg_wr_addr;
  logic [7:0]   reg_wr_data;
  logic         update_pulse;
  logic         frame_error;
  logic [127:0] cfg_regs;

  int checks = 0;
  int errors = 0;
  int strobe_cycles = 0;
  int upd_cycles = 0;
  int ferr_cycles = 0;
  logic [7:0] exp_regs [16];

  dragster_spi_responder dut (
    .clk           (clk),
    .reset         (reset),
    .sclk          (sclk),
    .mosi          (mosi),
    .ss_n          (ss_n),
    .miso          (miso),
    .miso_oe       (miso_oe),
    .reg_wr_strobe (reg_wr_strobe),
    .reg_wr_addr   (reg_wr_addr),
    .reg_wr_data   (reg_wr_data),
    .update_pulse  (update_pulse),
    .frame_error   (frame_error),
    .cfg_regs      (cfg_regs)
  );

  always #5 clk = ~clk;

  // Pulse-cycle counters sampled away from the active edge
  always @(negedge clk) begin
    if (reg_wr_strobe === 1'b1) strobe_cycles <= strobe_cycles + 1;
    if (update_pulse === 1'b1)  upd_cycles    <= upd_cycles + 1;
    if (frame_error === 1'b1)   ferr_cycles   <= ferr_cycles + 1;
  end

  function automatic logic [127:0] pack_exp();
    logic [127:0] v;
    v = 128'd0;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = exp_regs[i];
    return v;
  endfunction

  // One SPI bit: mosi set up, miso captured just before the rising edge
  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    repeat (5) @(negedge clk);
    m = miso;
    sclk = 1'b1;
    repeat (5) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] word, input int nbits, output logic [15:0] cap);
    logic m;
    cap = 16'h0000;
    @(negedge clk);
    ss_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_bit((i < 16) ? word[15-i] : 1'b0, m);
      if (i < 16) cap[15-i] = m;
    end
    repeat (5) @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (cfg_regs !== 128'd0) begin errors++; $display("FAIL reset_cfg: got %h expected 0", cfg_regs); end
    checks++; if ({miso, miso_oe, reg_wr_strobe, update_pulse, frame_error} !== 5'b00000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 00000", {miso, miso_oe, reg_wr_strobe, update_pulse, frame_error}); end
    checks++; if ({reg_wr_addr, reg_wr_data} !== 15'd0) begin
      errors++; $display("FAIL reset_wr_regs: got %h/%h expected 0/0", reg_wr_addr, reg_wr_data); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
  endtask

  task automatic test_single_write();
    logic [15:0] cap;
    int s0;
    s0 = strobe_cycles;
    send_frame(16'h3B05, 16, cap);
    exp_regs[5] = 8'h3B;
    checks++; if (cfg_regs !== pack_exp()) begin errors++; $display("FAIL single_cfg: got %h expected %h", cfg_regs, pack_exp()); end
    checks++; if (strobe_cycles - s0 !== 1) begin errors++; $display("FAIL single_strobe_cycles: got %0d expected 1", strobe_cycles - s0); end
    checks++; if (reg_wr_addr !== 7'd5) begin errors++; $display("FAIL single_addr: got %0d expected 5", reg_wr_addr); end
    checks++; if (reg_wr_data !== 8'h3B) begin errors++; $display("FAIL single_data: got %h expected 3b", reg_wr_data); end
  endtask

  task automatic test_sequence();
    logic [15:0] cap;
    logic [15:0] frames [5];
    int s0, u0;
    frames[0] = 16'h3B05; frames[1] = 16'h2202; frames[2] = 16'h8003;
    frames[3] = 16'h1F09; frames[4] = 16'hA101;
    s0 = strobe_cycles; u0 = upd_cycles;
    for (int k = 0; k < 4; k++) send_frame(frames[k], 16, cap);
    checks++; if (upd_cycles - u0 !== 0) begin errors++; $display("FAIL seq_update_early: got %0d expected 0", upd_cycles - u0); end
    send_frame(frames[4], 16, cap);
    exp_regs[5] = 8'h3B; exp_regs[2] = 8'h22; exp_regs[3] = 8'h80;
    exp_regs[9] = 8'h1F; exp_regs[1] = 8'hA1;
    checks++; if (cfg_regs !== pack_exp()) begin errors++; $display("FAIL seq_cfg: got %h expected %h", cfg_regs, pack_exp()); end
    checks++; if (strobe_cycles - s0 !== 5) begin errors++; $display("FAIL seq_strobes: got %0d expected 5", strobe_cycles - s0); end
    checks++; if (upd_cycles - u0 !== 1) begin errors++; $display("FAIL seq_update: got %0d expected 1", upd_cycles - u0); end
    checks++; if ({reg_wr_addr, reg_wr_data} !== {7'd1, 8'hA1}) begin
      errors++; $display("FAIL seq_last_wr: got %h/%h expected 01/a1", reg_wr_addr, reg_wr_data); end
  endtask

  task automatic test_frame_errors();
    logic [15:0] cap;
    int s0, f0;
    s0 = strobe_cycles; f0 = ferr_cycles;
    send_frame(16'h5506, 15, cap);
    checks++; if (ferr_cycles - f0 !== 1) begin errors++; $display("FAIL ferr_short: got %0d expected 1", ferr_cycles - f0); end
    send_frame(16'h6607, 17, cap);
    checks++; if (ferr_cycles - f0 !== 2) begin errors++; $display("FAIL ferr_long: got %0d expected 2", ferr_cycles - f0); end
    checks++; if (strobe_cycles - s0 !== 0) begin errors++; $display("FAIL ferr_strobe: got %0d expected 0", strobe_cycles - s0); end
    checks++; if (cfg_regs !== pack_exp()) begin errors++; $display("FAIL ferr_cfg: got %h expected %h", cfg_regs, pack_exp()); end
  endtask

  task automatic test_update_clear();
    logic [15:0] cap;
    int s0, u0;
    s0 = strobe_cycles; u0 = upd_cycles;
    send_frame(16'h7F01, 16, cap);
    exp_regs[1] = 8'h7F;
    checks++; if (cfg_regs !== pack_exp()) begin errors++; $display("FAIL upd_clr_cfg: got %h expected %h", cfg_regs, pack_exp()); end
    checks++; if (strobe_cycles - s0 !== 1) begin errors++; $display("FAIL upd_clr_strobe: got %0d expected 1", strobe_cycles - s0); end
    checks++; if (upd_cycles - u0 !== 0) begin errors++; $display("FAIL upd_clr_pulse: got %0d expected 0", upd_cycles - u0); end
  endtask

`ifdef DRAGSTER_SPI_READBACK_EN
  task automatic test_readback();
    logic [15:0] cap;
    send_frame(16'h3B05, 16, cap);
    send_frame(16'h0085, 16, cap);
    checks++; if (cap !== 16'h3B05) begin errors++; $display("FAIL rb_echo: got %h expected 3b05", cap); end
    send_frame(16'h0000, 16, cap);
    exp_regs[0] = 8'h00;
    checks++; if (cap !== 16'h3B85) begin errors++; $display("FAIL rb_read5: got %h expected 3b85", cap); end
    send_frame(16'h0095, 16, cap);
    send_frame(16'h0000, 16, cap);
    checks++; if (cap !== 16'h0095) begin errors++; $display("FAIL rb_read_oob: got %h expected 0095", cap); end
    checks++; if ({miso, miso_oe} !== 2'b00) begin errors++; $display("FAIL rb_idle_miso: got %b expected 00", {miso, miso_oe}); end
  endtask
`else
  task automatic test_read_discard();
    logic [15:0] cap;
    int s0, f0;
    s0 = strobe_cycles; f0 = ferr_cycles;
    send_frame(16'h0085, 16, cap);
    checks++; if (cap !== 16'h0000) begin errors++; $display("FAIL nrb_miso: got %h expected 0000", cap); end
    checks++; if ({strobe_cycles - s0, ferr_cycles - f0} !== {32'd0, 32'd0}) begin
      errors++; $display("FAIL nrb_pulses: got %0d/%0d expected 0/0", strobe_cycles - s0, ferr_cycles - f0); end
    checks++; if (cfg_regs !== pack_exp()) begin errors++; $display("FAIL nrb_cfg: got %h expected %h", cfg_regs, pack_exp()); end
  endtask
`endif

  task automatic test_reset_midframe();
    logic [15:0] w;
    logic [15:0] cap;
    logic m;
    int s0, f0;
    w = 16'hC3A5;
    @(negedge clk);
    ss_n = 1'b0;
    for (int i = 0; i < 8; i++) spi_bit(w[15-i], m);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cfg_regs !== 128'd0) begin errors++; $display("FAIL mid_reset_cfg: got %h expected 0", cfg_regs); end
    checks++; if ({reg_wr_strobe, update_pulse, frame_error, reg_wr_addr, reg_wr_data} !== 18'd0) begin
      errors++; $display("FAIL mid_reset_outs: got %h expected 0", {reg_wr_strobe, update_pulse, frame_error, reg_wr_addr, reg_wr_data}); end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    s0 = strobe_cycles; f0 = ferr_cycles;
    repeat (2) @(negedge clk);
    checks++; if ({miso, miso_oe} !== 2'b00) begin errors++; $display("FAIL mid_after_miso: got %b expected 00", {miso, miso_oe}); end
    for (int i = 8; i < 16; i++) spi_bit(w[15-i], m);
    repeat (5) @(negedge clk);
    ss_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if ({strobe_cycles - s0, ferr_cycles - f0} !== {32'd0, 32'd0}) begin
      errors++; $display("FAIL mid_tail_ignored: got %0d/%0d expected 0/0", strobe_cycles - s0, ferr_cycles - f0); end
    send_frame(16'h1F09, 16, cap);
    exp_regs[9] = 8'h1F;
    checks++; if (cfg_regs !== pack_exp()) begin errors++; $display("FAIL mid_next_frame: got %h expected %h", cfg_regs, pack_exp()); end
    checks++; if (strobe_cycles - s0 !== 1) begin errors++; $display("FAIL mid_next_strobe: got %0d expected 1", strobe_cycles - s0); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_sequence();
    test_frame_errors();
    test_update_clear();
`ifdef DRAGSTER_SPI_READBACK_EN
    test_readback();
`else
    test_read_discard();
`endif
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dragster_spi_responder.md
Name: dragster_spi_responder

Overview:
SPI target that models the Dragster linear sensor configuration port: the far end of the configuration master. It deserializes 16-bit MSB-first frames into an on-chip 8-bit register file and exposes the registers and write strobes in parallel. It also returns register contents on miso. Used as the sensor stand-in in system simulation, and as a loopback target on boards without a sensor.

Parameters:
NUM_REGS, 16, number of 8-bit registers; addresses 0..NUM_REGS-1.
SYNC_STAGES, 2, flip-flop stages synchronising sclk, mosi and ss_n into the clk domain (minimum 2).
UPDATE_ADDR, 1, address of the register that carries the update bit.
UPDATE_BIT, 7, bit position of the update bit inside UPDATE_ADDR.

Ports:
clk  in  1  system clock; must be at least 8x the sclk frequency.
reset  in  1  asynchronous, active-high reset.
sclk  in  1  SPI clock from master, mode 0 (idle low).
mosi  in  1  SPI data from master.
ss_n  in  1  slave select, active low.
miso  out  1  SPI data to master.
miso_oe  out  1  miso output enable; high while ss_n is low.
reg_wr_strobe  out  1  one-cycle pulse when a register is written.
reg_wr_addr  out  7  address of the last write.
reg_wr_data  out  8  data of the last write.
update_pulse  out  1  one-cycle pulse when a write to UPDATE_ADDR has bit UPDATE_BIT set.
frame_error  out  1  one-cycle pulse when a frame does not contain exactly 16 bits.
cfg_regs  out  8*NUM_REGS  flattened register file; register i occupies bits [8i+7:8i].

Behaviour:
- Reset (asynchronous, while reset=1): all outputs are 0, cfg_regs is all 0, the bit counter and shift registers clear, and the FSM goes to WAIT_IDLE.
- Input synchronisation: sclk, mosi and ss_n each pass through SYNC_STAGES flip-flops. Edges are detected from the synchronised value and its one-cycle-delayed copy.
- Frame format: 16 bits, MSB first, sampled on sclk rising edges.
  - Bits [15:8] carry data.
  - Bits [7:0] carry the address byte: bit 7 is the read flag (1 = read), bits [6:0] are the address.
- Miso: shifted on sclk falling edges, MSB first, from a 16-bit response register.
  - Bit 15 is driven as soon as ss_n falls.
  - miso is 0 whenever ss_n is high.
- FSM states:
  - WAIT_IDLE: wait for synchronised ss_n high, then go to IDLE. This prevents a mid-frame start after reset.
  - IDLE: on an ss_n falling edge, clear the bit counter (5 bits, saturating at 17), load miso from the response register, go to SHIFT.
  - SHIFT: each sclk rising edge shifts mosi into rx[0] and increments the counter. On an ss_n rising edge, go to COMMIT.
  - COMMIT: lasts one clk cycle, then return to IDLE.
    - Counter != 16: pulse frame_error; no register change, no strobe.
    - Write frame with address < NUM_REGS: cfg_regs[addr] <= data; reg_wr_strobe=1; reg_wr_addr and reg_wr_data latched; update_pulse=1 if addr==UPDATE_ADDR and data[UPDATE_BIT]=1.
    - Write frame with address >= NUM_REGS: discarded silently, no pulses.
    - Response register for the next frame:
      - After a write: echo of the received frame.
      - After a valid read: {cfg_regs[addr], address byte}.
      - After an out-of-range read: {8'h00, address byte}.
      - After a frame error: unchanged.
- Latency: the write is visible on cfg_regs and the strobe asserts SYNC_STAGES+2 clk cycles after ss_n rises at the pin.
- Edge cases:
  - sclk edges while ss_n is high are ignored.
  - ss_n falling and rising inside the same synchronised sample window is treated as an empty frame: counter 0, frame_error.
  - Back-to-back frames need ss_n high for at least SYNC_STAGES+2 clk cycles.
  - A frame longer than 16 bits saturates the counter and produces frame_error.

Optional Feature:
DRAGSTER_SPI_READBACK_EN
- Defined: read frames (address-byte bit 7 = 1) load the response register as described above, and miso drives the response.
- Not defined:
  - Frames with bit 7 set are discarded without error.
  - The response register is removed; miso and miso_oe are tied to 0.
  - Writes and all other behaviour are unchanged.

Test Plan:
- Frame 16'h3B05 (mosi value 0x3B05), sclk = clk/10 -> cfg_regs[5]=8'h3B; reg_wr_strobe exactly one cycle with reg_wr_addr=5, reg_wr_data=8'h3B; no other register changes.
- Frames 3B05, 2202, 8003, 1F09, A101 in sequence -> regs 5/2/3/9/1 = 3B/22/80/1F/A1; exactly 5 strobes; update_pulse exactly once, on the A101 frame.
- 15-bit frame, then 17-bit frame -> frame_error pulses twice; cfg_regs unchanged; no strobe.
- Readback (macro on): after writing 3B05, send frame 16'h0085, then frame 16'h0000 -> miso during the second frame shifts 16'h3B85; frame 16'h0095 (addr 21, out of range) then 16'h0000 -> miso shifts 16'h0095.
- Assert reset after 8 bits of a frame, with ss_n held low after release -> outputs 0; the rest of that frame is ignored until ss_n goes high; the next full 16'h1F09 frame writes reg9=8'h1F.
- Write 16'h7F01 (update bit clear) -> reg1=8'h7F, strobe asserted, update_pulse stays 0.
